// File: rtl/mig_write_sequencer.sv
// Writes 128-bit chunks to DDR through the MIG app_* interface,
// one command and one write-data beat per chunk, sequential addresses per frame.
module mig_write_sequencer #(
    parameter int ADDR_WIDTH  = 27,
    parameter int BASE_ADDR   = 0,
    parameter int ADDR_STRIDE = 8,
    parameter int MAX_WORDS   = 4800
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  init_calib_complete,
    input  logic                  chunk_tvalid,
    output logic                  chunk_tready,
    input  logic [127:0]          chunk_tdata,
    input  logic                  chunk_tlast,
    output logic [ADDR_WIDTH-1:0] app_addr,
    output logic [2:0]            app_cmd,
    output logic                  app_en,
    input  logic                  app_rdy,
    output logic [127:0]          app_wdf_data,
    output logic [15:0]           app_wdf_mask,
    output logic                  app_wdf_wren,
    output logic                  app_wdf_end,
    input  logic                  app_wdf_rdy,
    output logic                  frame_done,
    output logic                  wrap_err
);

    localparam int CNT_W = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(ADDR_STRIDE);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_WORDS - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t             state;
    state_t             next_state;
    logic               last_q;
    logic               cmd_done;
    logic               data_done;
    logic [CNT_W-1:0]   count;
    logic               accept;
    logic               cmd_hs;
    logic               data_hs;
    logic               word_done;

    // Strobes come straight from state so reset drops them asynchronously.
    assign app_en       = (state == ISSUE) && !cmd_done;
    assign app_wdf_wren = (state == ISSUE) && !data_done;
    assign app_wdf_end  = app_wdf_wren;
    assign app_cmd      = 3'b000;
    assign app_wdf_mask = 16'h0000;
    assign chunk_tready = (state == IDLE) && init_calib_complete;

    always_comb begin
        next_state = state;
        accept     = chunk_tvalid && chunk_tready;
        cmd_hs     = app_en && app_rdy;
        data_hs    = app_wdf_wren && app_wdf_rdy;
        word_done  = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) next_state = ISSUE;
            end
            ISSUE: begin
                word_done = (cmd_done || cmd_hs) && (data_done || data_hs);
                if (word_done) next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state        <= IDLE;
            app_addr     <= BASE;
            app_wdf_data <= '0;
            last_q       <= 1'b0;
            cmd_done     <= 1'b0;
            data_done    <= 1'b0;
            count        <= '0;
            frame_done   <= 1'b0;
            wrap_err     <= 1'b0;
        end else begin
            state      <= next_state;
            frame_done <= 1'b0;
            if (accept) begin
                app_wdf_data <= chunk_tdata;
                last_q       <= chunk_tlast;
            end
            if (word_done) begin
                cmd_done  <= 1'b0;
                data_done <= 1'b0;
                if (last_q) begin
                    app_addr   <= BASE;
                    count      <= '0;
                    frame_done <= 1'b1;
                end else if (count == LAST_CNT) begin
                    app_addr <= BASE;
                    count    <= '0;
                    wrap_err <= 1'b1;
                end else begin
                    app_addr <= app_addr + STRIDE;
                    count    <= count + CNT_W'(1);
                end
            end else begin
                if (cmd_hs) cmd_done <= 1'b1;
                if (data_hs) data_done <= 1'b1;
            end
        end
    end

endmodule
